// File: rtl/instr_trace_unit.sv
// Per-cycle instruction trace/profiling block: classifies IF-stage instructions,
// keeps saturating counters and buffers {pc, class[, wd]} records. Define TRACE_WD_EN to carry writeback data.
module instr_trace_unit #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    input  logic [DATA_W-1:0]        in_wd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [4:0]               out_class,
`ifdef TRACE_WD_EN
    output logic [DATA_W-1:0]        out_wd,
`endif
    input  logic [4:0]               cnt_sel,
    output logic [CNT_W-1:0]         cnt_value,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int NCLS = 17;
`ifdef TRACE_WD_EN
    localparam int ENTRY_W = PC_W + 5 + DATA_W;
`else
    localparam int ENTRY_W = PC_W + 5;
`endif

    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [AW:0]      LVL_ONE  = 1;
    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);

    localparam logic [4:0] C_NOP   = 5'd0;
    localparam logic [4:0] C_ADD   = 5'd1;
    localparam logic [4:0] C_SUB   = 5'd2;
    localparam logic [4:0] C_AND   = 5'd3;
    localparam logic [4:0] C_OR    = 5'd4;
    localparam logic [4:0] C_SLT   = 5'd5;
    localparam logic [4:0] C_SRL   = 5'd6;
    localparam logic [4:0] C_MULTU = 5'd7;
    localparam logic [4:0] C_MFHI  = 5'd8;
    localparam logic [4:0] C_MFLO  = 5'd9;
    localparam logic [4:0] C_MADDU = 5'd10;
    localparam logic [4:0] C_LW    = 5'd11;
    localparam logic [4:0] C_SW    = 5'd12;
    localparam logic [4:0] C_BEQ   = 5'd13;
    localparam logic [4:0] C_J     = 5'd14;
    localparam logic [4:0] C_ADDIU = 5'd15;
    localparam logic [4:0] C_OTHER = 5'd16;

    function automatic logic [4:0] classify(input logic [5:0] op, input logic [5:0] fn);
        logic [4:0] c;
        c = C_OTHER;
        if (op == 6'h00) begin
            case (fn)
                6'h00:   c = C_NOP;
                6'h20:   c = C_ADD;
                6'h22:   c = C_SUB;
                6'h24:   c = C_AND;
                6'h25:   c = C_OR;
                6'h2A:   c = C_SLT;
                6'h02:   c = C_SRL;
                6'h19:   c = C_MULTU;
                6'h10:   c = C_MFHI;
                6'h12:   c = C_MFLO;
                default: c = C_OTHER;
            endcase
        end else begin
            case (op)
                6'h1C:   c = C_MADDU;
                6'h23:   c = C_LW;
                6'h2B:   c = C_SW;
                6'h04:   c = C_BEQ;
                6'h02:   c = C_J;
                6'h09:   c = C_ADDIU;
                default: c = C_OTHER;
            endcase
        end
        return c;
    endfunction

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [CNT_W-1:0]   cls_cnt [NCLS];
    logic [CNT_W-1:0]   cyc_cnt, drp_cnt;
    logic               ovf;

    logic               capture, pop, push, full;
    logic [4:0]         cur_class;
    logic [ENTRY_W-1:0] entry, head;

    // Handshake: a record transfers on any edge where out_valid && out_ready are both
    // high; out_valid never depends on out_ready, and clear overrides the transfer.
    assign capture   = en && in_valid && !clear;
    assign full      = (count == LVL_FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !clear;
    assign push      = capture && (!full || pop);
    assign cur_class = classify(in_instr[31:26], in_instr[5:0]);

`ifdef TRACE_WD_EN
    assign entry = {in_pc, cur_class, in_wd};
    logic unused_bits;
    assign unused_bits = ^in_instr[25:6];
`else
    assign entry = {in_pc, cur_class};
    logic unused_bits;
    assign unused_bits = ^{in_instr[25:6], in_wd};
`endif

    // Storage is not reset; head outputs are gated by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCLS; i++) cls_cnt[i] <= '0;
            cyc_cnt <= '0;
            drp_cnt <= '0;
            ovf     <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < NCLS; i++) cls_cnt[i] <= '0;
            cyc_cnt <= '0;
            drp_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (en && cyc_cnt != CNT_MAX) cyc_cnt <= cyc_cnt + CNT_ONE;
            if (capture && cls_cnt[cur_class] != CNT_MAX)
                cls_cnt[cur_class] <= cls_cnt[cur_class] + CNT_ONE;
            // Class counters see every capture; only the FIFO push can be lost.
            if (capture && !push) begin
                ovf <= 1'b1;
                if (drp_cnt != CNT_MAX) drp_cnt <= drp_cnt + CNT_ONE;
            end
        end
    end

    assign head      = mem[rd_ptr];
    assign out_pc    = out_valid ? head[ENTRY_W-1 -: PC_W] : '0;
    assign out_class = out_valid ? head[ENTRY_W-PC_W-1 -: 5] : '0;
`ifdef TRACE_WD_EN
    assign out_wd    = out_valid ? head[DATA_W-1:0] : '0;
`endif

    assign cnt_value   = (cnt_sel < 5'd17) ? cls_cnt[cnt_sel] : '0;
    assign cycle_count = cyc_cnt;
    assign drop_count  = drp_cnt;
    assign overflow    = ovf;
    assign level       = count;

endmodule

// File: doc/instr_trace_unit.md
# instr_trace_unit

Synthesizable per-cycle instruction trace and profiling block for the pipelined MIPS core. Samples the IF-stage PC/instruction (and optionally writeback data) each enabled cycle, classifies the instruction into one of 17 classes, keeps saturating per-class and cycle counters, and buffers `{pc, class[, wd]}` records in a parametrised FIFO drained through a valid/ready port. Sits beside the CPU top level and replaces per-cycle simulation printouts with hardware-visible, bench-checkable state.

## Interface
- `PC_W`, 32, PC width
- `DATA_W`, 32, writeback data width
- `DEPTH`, 16, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of all counters

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `clear`  in  1  synchronous clear of counters, FIFO, flags
- `en`  in  1  capture enable
- `in_valid`  in  1  sample qualifies this cycle
- `in_pc`  in  PC_W  PC of sampled instruction
- `in_instr`  in  32  sampled instruction word
- `in_wd`  in  DATA_W  writeback data (used only with `TRACE_WD_EN`)
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_pc`  out  PC_W  head PC
- `out_class`  out  5  head class code
- `out_wd`  out  DATA_W  head writeback data (present only with `TRACE_WD_EN`)
- `cnt_sel`  in  5  class counter select
- `cnt_value`  out  CNT_W  selected class count
- `cycle_count`  out  CNT_W  enabled cycles since reset/clear
- `drop_count`  out  CNT_W  records lost to full FIFO
- `overflow`  out  1  sticky: at least one drop
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Capture condition: `en && in_valid && !clear`.
- Classes (opcode = instr[31:26], funct = instr[5:0]): opcode 0 → funct 0x00 NOP=0, 0x20 ADD=1, 0x22 SUB=2, 0x24 AND=3, 0x25 OR=4, 0x2A SLT=5, 0x02 SRL=6, 0x19 MULTU=7, 0x10 MFHI=8, 0x12 MFLO=9, other funct OTHER=16; opcode 0x1C MADDU=10, 0x23 LW=11, 0x2B SW=12, 0x04 BEQ=13, 0x02 J=14, 0x09 ADDIU=15, anything else OTHER=16.
- On capture: class counter increments (saturates at 2^CNT_W−1); record pushed to FIFO if not full or if a pop occurs the same cycle; else record dropped, `drop_count` increments (saturating), `overflow` set.
- Counters count every capture regardless of FIFO drops.
- `cycle_count` increments every cycle `en`=1 and `clear`=0, saturating.
- Pop when `out_valid && out_ready`; independent of `en`.
- `cnt_value` = counter[`cnt_sel`] combinationally; `cnt_sel` 17–31 → 0.
- `clear`: all counters, FIFO pointers, `overflow` to 0 next edge; has priority over capture and pop in the same cycle.

## Timing
- Reset (`rst`=0, async): all counters 0, `level`=0, `out_valid`=0, `overflow`=0, `out_pc`/`out_class`/`out_wd`=0.
- Capture at edge N → counter visible and record at head (if FIFO was empty) after edge N; `out_valid`=1 in cycle N+1.
- Throughput: one push and one pop per cycle; full + simultaneous push/pop → both accepted, `level` stays `DEPTH`, no drop.
- Empty + push + `out_ready`=1: push accepted, no pop that cycle (no fall-through).
- Pointers wrap modulo `DEPTH`; `level` ranges 0..`DEPTH`.
- Head outputs hold stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-burst discards FIFO contents immediately; no partial records after release.

## Configuration
- `TRACE_WD_EN` defined: FIFO entries include `in_wd`; `out_wd` port exists and carries head data.
- Not defined: `out_wd` port absent, FIFO width is PC_W+5 only; `in_wd` ignored.

## Test plan
- Reset then push ADD (0x00221820) at PC 0x0, LW (0x8C010004) at PC 0x4 with `out_ready`=0 → `level`=2, head `{0x0,1}`; `cnt_sel`=1 and 11 → 1 each.
- 17 captures into `DEPTH`=16 with `out_ready`=0 → `level`=16, `drop_count`=1, `overflow`=1; drain yields PCs of first 16 in order.
- Full FIFO, capture with `out_ready`=1 same cycle → `level` remains 16, `drop_count` unchanged.
- `en`=0 for 5 cycles with `in_valid`=1 → no counter change, `cycle_count` frozen; draining continues.
- Assert `clear` concurrently with capture and pop → next cycle all counters 0, `level`=0, `overflow`=0; `cnt_sel`=20 → 0.
- With `CNT_W`=4, 20 NOP captures → NOP count 15 (saturated); with `TRACE_WD_EN`, `out_wd` matches pushed `in_wd`.
